// File: rtl/axi_sram_slave_if.sv
// axi_sram_slave_if: LSU-side AXI-lite style bus to the SRAM responder.
// master = LSU load/store port, slave = axi_sram_slave.
interface axi_sram_slave_if #(
  parameter int DATA_LEN     = 32,
  parameter int DATA_BIT_NUM = 4
);
  logic                    awvalid;
  logic                    awready;
  logic [DATA_LEN-1:0]     waddr;
  logic                    wvalid;
  logic                    wready;
  logic [DATA_LEN-1:0]     wdata;
  logic [DATA_BIT_NUM-1:0] wstrb;
  logic                    bvalid;
  logic                    bready;
  logic [2:0]              bresp;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_LEN-1:0]     raddr;
  logic                    rvalid;
  logic                    rready;
  logic [2:0]              rresp;
  logic [DATA_LEN-1:0]     rdata;

  modport master (
    output awvalid, waddr, wvalid, wdata, wstrb,
    output bready, arvalid, raddr, rready,
    input  awready, wready, bvalid, bresp,
    input  arready, rvalid, rresp, rdata
  );

  modport slave (
    input  awvalid, waddr, wvalid, wdata, wstrb,
    input  bready, arvalid, raddr, rready,
    output awready, wready, bvalid, bresp,
    output arready, rvalid, rresp, rdata
  );
endinterface

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: word SRAM responder with independent read/write FSMs,
// programmable response latency, byte strobes and SLVERR on out-of-range.
module axi_sram_slave #(
  parameter int DATA_LEN     = 32,
  parameter int DATA_BIT_NUM = 4,
  parameter int MEM_AW       = 10,
  parameter int RD_LATENCY   = 1,
  parameter int WR_LATENCY   = 1
) (
  input logic             clk,
  input logic             rst_n,
  axi_sram_slave_if.slave bus
);
  localparam int CW = 8;
  localparam logic [2:0] OKAY   = 3'b000;
  localparam logic [2:0] SLVERR = 3'b010;

  typedef enum logic [1:0] {
    R_IDLE, R_WAIT, R_RESP
  } r_state_e;

  typedef enum logic [2:0] {
    W_IDLE, W_HAVE_AW, W_HAVE_W, W_WAIT, W_RESP
  } w_state_e;

  logic [DATA_LEN-1:0] mem_q [2**MEM_AW];

  r_state_e            r_state_q;
  logic                arready_q;
  logic                rvalid_q;
  logic [2:0]          rresp_q;
  logic [DATA_LEN-1:0] rdata_q;
  logic [DATA_LEN-1:0] raddr_q;
  logic [CW-1:0]       rcnt_q;

  w_state_e                w_state_q;
  logic                    awready_q;
  logic                    wready_q;
  logic                    bvalid_q;
  logic [2:0]              bresp_q;
  logic [DATA_LEN-1:0]     waddr_q;
  logic [DATA_LEN-1:0]     wdata_q;
  logic [DATA_BIT_NUM-1:0] wstrb_q;
  logic [CW-1:0]           wcnt_q;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
  assign ar_hs = bus.arvalid & arready_q;
  assign r_hs  = bus.rready  & rvalid_q;
  assign aw_hs = bus.awvalid & awready_q;
  assign w_hs  = bus.wvalid  & wready_q;
  assign b_hs  = bus.bready  & bvalid_q;

  // Direct-to-response paths use the bus values before they are latched
  logic [DATA_LEN-1:0]     ra, wa, wd;
  logic [DATA_BIT_NUM-1:0] ws;
  assign ra = ar_hs ? bus.raddr : raddr_q;
  assign wa = aw_hs ? bus.waddr : waddr_q;
  assign wd = w_hs  ? bus.wdata : wdata_q;
  assign ws = w_hs  ? bus.wstrb : wstrb_q;

  logic              r_oor, w_oor;
  logic [MEM_AW-1:0] r_idx, w_idx;
  assign r_oor = |ra[DATA_LEN-1:MEM_AW+2];
  assign w_oor = |wa[DATA_LEN-1:MEM_AW+2];
  assign r_idx = ra[MEM_AW+1:2];
  assign w_idx = wa[MEM_AW+1:2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{ra[1:0], wa[1:0]};

  logic w_both;
  always_comb begin
    w_both = 1'b0;
    unique case (w_state_q)
      W_IDLE:    w_both = aw_hs & w_hs;
      W_HAVE_AW: w_both = w_hs;
      W_HAVE_W:  w_both = aw_hs;
      default:   w_both = 1'b0;
    endcase
  end

  logic r_enter, w_enter;
  assign r_enter =
    (r_state_q == R_IDLE && ar_hs && RD_LATENCY == 1) ||
    (r_state_q == R_WAIT && rcnt_q == CW'(1));
  assign w_enter =
    (w_both && WR_LATENCY == 1) ||
    (w_state_q == W_WAIT && wcnt_q == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= OKAY;
      rdata_q   <= '0;
      raddr_q   <= '0;
      rcnt_q    <= '0;
    end else begin
      unique case (r_state_q)
        R_IDLE: begin
          arready_q <= ~ar_hs;
          if (ar_hs) begin
            raddr_q   <= bus.raddr;
            rcnt_q    <= CW'(RD_LATENCY - 1);
            r_state_q <= (RD_LATENCY == 1) ? R_RESP : R_WAIT;
          end
        end
        R_WAIT: begin
          rcnt_q <= rcnt_q - CW'(1);
          if (rcnt_q == CW'(1)) r_state_q <= R_RESP;
        end
        R_RESP: begin
          if (r_hs) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            r_state_q <= R_IDLE;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
      // Nonblocking read: a same-edge write is not yet visible here
      if (r_enter) begin
        rvalid_q <= 1'b1;
        rresp_q  <= r_oor ? SLVERR : OKAY;
        rdata_q  <= r_oor ? '0 : mem_q[r_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      waddr_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wcnt_q    <= '0;
    end else begin
      if (aw_hs) waddr_q <= bus.waddr;
      if (w_hs) begin
        wdata_q <= bus.wdata;
        wstrb_q <= bus.wstrb;
      end
      unique case (w_state_q)
        W_IDLE, W_HAVE_AW, W_HAVE_W: begin
          awready_q <= (w_state_q != W_HAVE_AW) & ~aw_hs;
          wready_q  <= (w_state_q != W_HAVE_W) & ~w_hs;
          if (w_both) begin
            wcnt_q    <= CW'(WR_LATENCY - 1);
            w_state_q <= (WR_LATENCY == 1) ? W_RESP : W_WAIT;
          end else if (aw_hs) begin
            w_state_q <= W_HAVE_AW;
          end else if (w_hs) begin
            w_state_q <= W_HAVE_W;
          end
        end
        W_WAIT: begin
          wcnt_q <= wcnt_q - CW'(1);
          if (wcnt_q == CW'(1)) w_state_q <= W_RESP;
        end
        W_RESP: begin
          if (b_hs) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
      if (w_enter) begin
        bvalid_q <= 1'b1;
        bresp_q  <= w_oor ? SLVERR : OKAY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_enter && !w_oor) begin
      for (int b = 0; b < DATA_BIT_NUM; b++) begin
        if (ws[b]) mem_q[w_idx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rresp   = rresp_q;
  assign bus.rdata   = rdata_q;
  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
endmodule

// File: tb/tb_axi_sram_slave.sv
// tb_axi_sram_slave: vector table plus scoreboard for axi_sram_slave,
// with a latency-1 instance (a) and a RD=3/WR=2 instance (b).
module tb_axi_sram_slave;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_sram_slave_if #(.DATA_LEN(32), .DATA_BIT_NUM(4)) ifa ();
  axi_sram_slave_if #(.DATA_LEN(32), .DATA_BIT_NUM(4)) ifb ();

  axi_sram_slave #(
    .DATA_LEN(32), .DATA_BIT_NUM(4), .MEM_AW(10),
    .RD_LATENCY(1), .WR_LATENCY(1)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));

  axi_sram_slave #(
    .DATA_LEN(32), .DATA_BIT_NUM(4), .MEM_AW(10),
    .RD_LATENCY(3), .WR_LATENCY(2)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));

  typedef struct packed {
    logic [31:0] data;
    logic [2:0]  resp;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [2:0]  exp_resp;
  } vec_t;

  exp_t sbq [$];
  vec_t vecs [15];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic sb_push(input logic [31:0] d, input logic [2:0] r);
    exp_t e;
    e.data = d;
    e.resp = r;
    sbq.push_back(e);
  endtask

  task automatic sb_pop(output exp_t e);
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL sb_empty actual=0 required=1");
      e = '0;
    end else begin
      e = sbq.pop_front();
    end
  endtask

  task automatic setv(input int i, input bit wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input logic [31:0] ed, input logic [2:0] er);
    vecs[i].wr = wr;
    vecs[i].addr = a;
    vecs[i].data = d;
    vecs[i].strb = s;
    vecs[i].exp_data = ed;
    vecs[i].exp_resp = er;
  endtask

  task automatic wr_a(input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s);
    exp_t e;
    int n;
    n = 0;
    while (!(ifa.awready && ifa.wready) && n < 50) begin
      @(negedge clk);
      n++;
    end
    ifa.awvalid = 1'b1; ifa.waddr = a;
    ifa.wvalid = 1'b1; ifa.wdata = d; ifa.wstrb = s;
    @(negedge clk);
    ifa.awvalid = 1'b0; ifa.wvalid = 1'b0;
    chk("a_b_latency", ifa.bvalid, 1);
    sb_pop(e);
    chk("a_bresp", ifa.bresp, e.resp);
    ifa.bready = 1'b1;
    @(negedge clk);
    ifa.bready = 1'b0;
  endtask

  task automatic rd_a(input logic [31:0] a);
    exp_t e;
    int n;
    n = 0;
    while (!ifa.arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    ifa.arvalid = 1'b1; ifa.raddr = a;
    @(negedge clk);
    ifa.arvalid = 1'b0;
    chk("a_r_latency", ifa.rvalid, 1);
    sb_pop(e);
    chk("a_rdata", ifa.rdata, e.data);
    chk("a_rresp", ifa.rresp, e.resp);
    ifa.rready = 1'b1;
    @(negedge clk);
    ifa.rready = 1'b0;
  endtask

  task automatic split_a(input bit aw_first, input logic [31:0] a,
                         input logic [31:0] d);
    ifa.waddr = a; ifa.wdata = d; ifa.wstrb = 4'hF;
    if (aw_first) ifa.awvalid = 1'b1;
    else ifa.wvalid = 1'b1;
    @(negedge clk);
    ifa.awvalid = 1'b0; ifa.wvalid = 1'b0;
    repeat (2) begin
      chk("split_hold", aw_first ? ifa.awready : ifa.wready, 0);
      chk("split_other", aw_first ? ifa.wready : ifa.awready, 1);
      chk("split_no_b", ifa.bvalid, 0);
      @(negedge clk);
    end
    if (aw_first) ifa.wvalid = 1'b1;
    else ifa.awvalid = 1'b1;
    @(negedge clk);
    ifa.awvalid = 1'b0; ifa.wvalid = 1'b0;
    chk("split_b", {ifa.bvalid, ifa.bresp}, 4'b1000);
    ifa.bready = 1'b1;
    @(negedge clk);
    ifa.bready = 1'b0;
    chk("split_rdy", {ifa.awready, ifa.wready}, 2'b11);
  endtask

  task automatic rd_b(input logic [31:0] a);
    exp_t e;
    int n;
    ifb.arvalid = 1'b1; ifb.raddr = a;
    @(negedge clk);
    ifb.arvalid = 1'b0;
    n = 1;
    while (!ifb.rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("b_r_latency", n, 3);
    sb_pop(e);
    chk("b_rdata", ifb.rdata, e.data);
    chk("b_rresp", ifb.rresp, e.resp);
    ifb.rready = 1'b1;
    @(negedge clk);
    ifb.rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    {ifa.awvalid, ifa.wvalid, ifa.bready, ifa.arvalid, ifa.rready} = '0;
    {ifb.awvalid, ifb.wvalid, ifb.bready, ifb.arvalid, ifb.rready} = '0;
    {ifa.waddr, ifa.wdata, ifa.wstrb, ifa.raddr} = '0;
    {ifb.waddr, ifb.wdata, ifb.wstrb, ifb.raddr} = '0;

    repeat (3) @(negedge clk);
    chk("rst_a_hs", {ifa.awready, ifa.wready, ifa.arready,
                     ifa.bvalid, ifa.rvalid}, 0);
    chk("rst_a_resp", {ifa.bresp, ifa.rresp}, 0);
    chk("rst_a_rdata", ifa.rdata, 0);
    chk("rst_b_hs", {ifb.awready, ifb.wready, ifb.arready,
                     ifb.bvalid, ifb.rvalid}, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst_a", {ifa.awready, ifa.wready, ifa.arready}, 3'b111);
    chk("rdy_after_rst_b", {ifb.awready, ifb.wready, ifb.arready}, 3'b111);

    setv(0,  1, 32'h10,   32'hDEADBEEF, 4'hF, '0, 3'b000);
    setv(1,  0, 32'h10,   '0, '0, 32'hDEADBEEF, 3'b000);
    setv(2,  1, 32'h10,   32'h11223344, 4'b0100, '0, 3'b000);
    setv(3,  0, 32'h10,   '0, '0, 32'hDE22BEEF, 3'b000);
    setv(4,  1, 32'h13,   32'hAABBCCDD, 4'b0001, '0, 3'b000);
    setv(5,  0, 32'h10,   '0, '0, 32'hDE22BEDD, 3'b000);
    setv(6,  1, 32'h0,    32'h12345678, 4'hF, '0, 3'b000);
    setv(7,  1, 32'h2000, 32'hFFFFFFFF, 4'hF, '0, 3'b010);
    setv(8,  0, 32'h0,    '0, '0, 32'h12345678, 3'b000);
    setv(9,  0, 32'h1000, '0, '0, 32'h0, 3'b010);
    setv(10, 1, 32'h10,   32'h0, 4'h0, '0, 3'b000);
    setv(11, 0, 32'h10,   '0, '0, 32'hDE22BEDD, 3'b000);
    setv(12, 1, 32'hFFC,  32'hCAFEF00D, 4'hF, '0, 3'b000);
    setv(13, 0, 32'hFFC,  '0, '0, 32'hCAFEF00D, 3'b000);
    setv(14, 0, 32'h0,    '0, '0, 32'h12345678, 3'b000);

    foreach (vecs[i]) begin
      sb_push(vecs[i].exp_data, vecs[i].exp_resp);
      if (vecs[i].wr) wr_a(vecs[i].addr, vecs[i].data, vecs[i].strb);
      else rd_a(vecs[i].addr);
    end

    split_a(1'b1, 32'h20, 32'h0BADF00D);
    split_a(1'b0, 32'h24, 32'h5555AAAA);
    sb_push(32'h0BADF00D, 3'b000);
    rd_a(32'h20);
    sb_push(32'h5555AAAA, 3'b000);
    rd_a(32'h24);

    ifb.awvalid = 1'b1; ifb.waddr = 32'h40;
    ifb.wvalid = 1'b1; ifb.wdata = 32'h13579BDF; ifb.wstrb = 4'hF;
    @(negedge clk);
    ifb.awvalid = 1'b0; ifb.wvalid = 1'b0;
    chk("b2_early", ifb.bvalid, 0);
    @(negedge clk);
    chk("b2_lat", {ifb.bvalid, ifb.bresp}, 4'b1000);
    ifb.bready = 1'b1;
    @(negedge clk);
    ifb.bready = 1'b0;

    sb_push(32'h13579BDF, 3'b000);
    ifb.arvalid = 1'b1; ifb.raddr = 32'h40;
    @(negedge clk);
    ifb.arvalid = 1'b0;
    chk("r3_c1", {ifb.rvalid, ifb.arready}, 0);
    @(negedge clk);
    chk("r3_c2", {ifb.rvalid, ifb.arready}, 0);
    @(negedge clk);
    sb_pop(e);
    repeat (4) begin
      chk("r3_stall_v", {ifb.rvalid, ifb.arready}, 2'b10);
      chk("r3_stall_d", ifb.rdata, e.data);
      chk("r3_stall_r", ifb.rresp, e.resp);
      @(negedge clk);
    end
    ifb.rready = 1'b1;
    @(negedge clk);
    ifb.rready = 1'b0;
    chk("r3_done", {ifb.rvalid, ifb.arready}, 2'b01);

    ifb.awvalid = 1'b1; ifb.waddr = 32'h40;
    ifb.arvalid = 1'b1; ifb.raddr = 32'h40;
    @(negedge clk);
    ifb.awvalid = 1'b0; ifb.arvalid = 1'b0;
    chk("pre_rst", {ifb.awready, ifb.wready, ifb.arready}, 3'b010);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valids", {ifb.rvalid, ifb.bvalid, ifa.rvalid, ifa.bvalid}, 0);
    chk("rst_readies", {ifb.arready, ifb.awready, ifb.wready}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_rdy", {ifb.awready, ifb.wready, ifb.arready}, 3'b111);

    // A W alone must not complete the aborted AW
    ifb.wvalid = 1'b1; ifb.wdata = 32'hFFFFFFFF; ifb.wstrb = 4'hF;
    @(negedge clk);
    ifb.wvalid = 1'b0;
    repeat (3) begin
      chk("post_rst_no_b", {ifb.bvalid, ifb.awready, ifb.wready}, 3'b010);
      @(negedge clk);
    end
    ifb.awvalid = 1'b1; ifb.waddr = 32'h80;
    @(negedge clk);
    ifb.awvalid = 1'b0;
    @(negedge clk);
    chk("post_rst_b", {ifb.bvalid, ifb.bresp}, 4'b1000);
    ifb.bready = 1'b1;
    @(negedge clk);
    ifb.bready = 1'b0;

    sb_push(32'h13579BDF, 3'b000);
    rd_b(32'h40);
    sb_push(32'hFFFFFFFF, 3'b000);
    rd_b(32'h80);
    chk("sb_drained", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/axi_sram_slave.md
Name: axi_sram_slave

Overview:
- AXI-lite style responder backing the LSU's load and store ports.
- Single-ported word memory with independent read and write channel state machines, programmable response latency, byte-strobe writes, and 3-bit response codes.
- Sits between the LSU master and the simulation/FPGA memory model; drives the ready/valid/resp signals that the LSU samples.

Parameters:
- DATA_LEN, 32, data and address width.
- DATA_BIT_NUM, 4, byte strobes per word (DATA_LEN/8).
- MEM_AW, 10, log2 of memory depth in words (1024 words).
- RD_LATENCY, 1, cycles from AR handshake to rvalid (>=1).
- WR_LATENCY, 1, cycles from capturing both AW and W to bvalid (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- waddr  in  DATA_LEN  write byte address.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- wdata  in  DATA_LEN  write data.
- wstrb  in  DATA_BIT_NUM  byte enables; bit i enables wdata[8i+7:8i].
- bvalid  out  1  write response valid.
- bready  in  1  write response accept.
- bresp  out  3  3'b000 OKAY, 3'b010 SLVERR.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- raddr  in  DATA_LEN  read byte address.
- rvalid  out  1  read data valid.
- rready  in  1  read data accept.
- rresp  out  3  same encoding as bresp.
- rdata  out  DATA_LEN  read data.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- All outputs are registered.
- Reset values: awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=3'b000, rdata=0. Both FSMs go to IDLE; counters clear; memory contents are not reset.
- Readies rise in the first cycle after rst_n deasserts.
- Address decode:
  - Word index = addr[MEM_AW+1:2]; addr[1:0] is ignored.
  - If addr[DATA_LEN-1:MEM_AW+2] != 0 the access is out of range: SLVERR, no memory write, rdata=0.
- Read FSM, states R_IDLE, R_WAIT, R_RESP:
  - R_IDLE: arready=1. On arvalid&arready, latch raddr, load counter with RD_LATENCY-1, drop arready. Go to R_RESP if RD_LATENCY==1, else R_WAIT.
  - R_WAIT: decrement the counter; at 0 go to R_RESP.
  - On entering R_RESP: rdata = mem[index], rresp set, rvalid=1.
  - R_RESP: hold rvalid/rdata/rresp stable until rvalid&rready, then rvalid=0, arready=1, back to R_IDLE.
  - The earliest next AR handshake is the cycle after the R handshake.
- Write FSM, states W_IDLE, W_HAVE_AW, W_HAVE_W, W_WAIT, W_RESP:
  - W_IDLE: awready=wready=1.
  - Both handshakes in the same cycle: latch address, data and strobe, then go to W_WAIT, or W_RESP if WR_LATENCY==1.
  - AW only: go to W_HAVE_AW with awready=0.
  - W only: go to W_HAVE_W with wready=0.
  - W_HAVE_AW waits for the W handshake; W_HAVE_W waits for the AW handshake; then proceed as above.
  - On entering W_RESP: write memory bytes where wstrb=1 (unless out of range); bresp set; bvalid=1.
  - W_RESP: hold until bvalid&bready, then back to W_IDLE with both readies high.
  - wstrb=0 gives OKAY and leaves memory unchanged.
- Simultaneous read and write:
  - The channels are independent.
  - If R_RESP entry and the W_RESP memory update occur on the same edge to the same word, rdata returns the old data.
  - A read whose R_RESP entry is later than the write update returns the new data.
- Back-pressure: an arbitrary number of cycles of rready=0 or bready=0 keeps the response stable and blocks new requests on that channel only.
- Reset mid-transaction: all FSMs abort to IDLE immediately with the reset values above. A pending write that has not reached W_RESP is discarded.

Test Plan:
- Reset, then write 0xDEADBEEF to 0x00000010 with wstrb=4'hF (AW and W together), then read 0x10. Required: bvalid 1 cycle after handshake with bresp=0; rvalid 1 cycle after AR handshake; rdata=0xDEADBEEF, rresp=0.
- Byte strobes: write 0x11223344 with wstrb=4'b0100 over 0xDEADBEEF at 0x10, then read. Required: rdata=0xDE22BEEF.
- Split handshakes: AW at cycle 0, W at cycle 3 (and the reverse order). Required: awready (or wready) low while waiting; bvalid only after both; data stored correctly.
- Latency and back-pressure with RD_LATENCY=3, WR_LATENCY=2, rready held low for 4 cycles. Required: rvalid exactly 3 cycles after AR; rdata stable while stalled; arready=0 until the R handshake.
- Out of range with MEM_AW=10: read 0x00001000 and write 0x00002000. Required: rresp=bresp=3'b010, rdata=0, memory unchanged on a read-back of word 0.
- Assert rst_n=0 while in W_HAVE_AW and R_WAIT. Required: all valids 0 immediately; after release readies are 1 and no write has occurred.
